// File: rtl/ksa_pkg.sv
// ksa_pkg: definitions shared by the PRESENT-80 key-schedule controller.
//   - default widths (master key, round key) and schedule length
//   - controller state type and the 6-bit round index type
//   - the PRESENT 4-bit S-box used by the key update
// `KEY_SIZE gives the master key width. It defaults to 80 when the
// surrounding build does not define it.
`ifndef KEY_SIZE
`define KEY_SIZE 80
`endif

package ksa_pkg;

  localparam int KEY_W_DEF      = `KEY_SIZE;
  localparam int RK_W_DEF       = 64;
  localparam int NUM_ROUNDS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ksa_state_e;

  // Round index 1..63. Six bits, so the schedule length is capped at 63.
  typedef logic [5:0] round_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/ksa_controller_if.sv
// ksa_controller_if: request / round-key handshake bundle for ksa_controller.
//   start, key_in      request a schedule with this master key
//   busy               a schedule is in progress
//   rk_valid, rk_ready valid/ready handshake for each round key
//   round_key, round   current round key and its index (1..NUM_ROUNDS)
//   done               one-cycle pulse after the last key has transferred
//   abort              only present when KSA_CTRL_ABORT_EN is defined
// Modports: master = requester/consumer side, slave = ksa_controller.
interface ksa_controller_if
  import ksa_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int RK_W  = RK_W_DEF
);

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [RK_W-1:0]  round_key;
  round_t           round;
  logic             done;
`ifdef KSA_CTRL_ABORT_EN
  logic             abort;
`endif

  modport master (
    output start,
    output key_in,
    output rk_ready,
`ifdef KSA_CTRL_ABORT_EN
    output abort,
`endif
    input  busy,
    input  rk_valid,
    input  round_key,
    input  round,
    input  done
  );

  modport slave (
    input  start,
    input  key_in,
    input  rk_ready,
`ifdef KSA_CTRL_ABORT_EN
    input  abort,
`endif
    output busy,
    output rk_valid,
    output round_key,
    output round,
    output done
  );

endinterface

// File: rtl/ksa_controller_ksa.sv
// ksa_controller_ksa: one step of the PRESENT-80 key schedule (combinational).
//   key      current key register (K_i is its top 64 bits)
//   round    index i of the key currently held
//   new_key  key register holding K_(i+1)
// Step: rotate left by 61, S-box the top nibble, XOR the 5-bit round
// counter into bits [19:15].
module ksa_controller_ksa
  import ksa_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  output logic [KEY_W-1:0] new_key,
  input  logic [KEY_W-1:0] key,
  input  round_t           round
);

  logic [KEY_W-1:0] rotated;
  // The round counter in PRESENT is 5 bits wide, so bit 5 is not used here.
  logic             unused_round_msb;

  // A left rotate by 61 is the same as a right rotate by 19.
  assign rotated          = {key[18:0], key[KEY_W-1:19]};
  assign unused_round_msb = round[5];

  always_comb begin
    new_key                = rotated;
    new_key[KEY_W-1 -: 4]  = present_sbox(rotated[KEY_W-1 -: 4]);
    new_key[19:15]         = rotated[19:15] ^ round[4:0];
  end

endmodule

// File: rtl/ksa_controller.sv
// ksa_controller: steps a PRESENT-80 key schedule and hands out round keys
// K1..K_NUM_ROUNDS one at a time over a valid/ready handshake.
// The consumer can stall the schedule at any time.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    ksa_controller_if.slave (start/key_in in, round keys out, done)
// Build option: KSA_CTRL_ABORT_EN adds bus.abort. When abort is high in
// RUN, the schedule is dropped and the controller returns to IDLE with
// no done pulse. Abort wins over a transfer in the same cycle.
// NUM_ROUNDS must lie in 1..63 because the round index is 6 bits wide.
module ksa_controller
  import ksa_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int RK_W       = RK_W_DEF
) (
  input logic            clk,
  input logic            reset,
  ksa_controller_if.slave bus
);

  ksa_state_e       state, state_d;
  logic [KEY_W-1:0] key_reg, key_d;
  round_t           round_q, round_d;
  logic [KEY_W-1:0] ksa_key;
  logic             last_round;

  ksa_controller_ksa #(
    .KEY_W (KEY_W)
  ) u_ksa (
    .new_key (ksa_key),
    .key     (key_reg),
    .round   (round_q)
  );

  assign last_round = (round_q == round_t'(NUM_ROUNDS));

  // NOTE: every variable gets a default first. This means no path through
  // the case leaves a value unassigned, so no latch is inferred.
  always_comb begin
    state_d = state;
    key_d   = key_reg;
    round_d = round_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          round_d = round_t'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef KSA_CTRL_ABORT_EN
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else
`endif
        if (bus.rk_ready) begin
          // rk_valid is always high in RUN, so ready alone means a transfer.
          if (last_round) begin
            state_d = ST_DONE;
          end else begin
            key_d   = ksa_key;
            round_d = round_q + round_t'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from the values it had before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      round_q <= '0;
    end else begin
      state   <= state_d;
      key_reg <= key_d;
      round_q <= round_d;
    end
  end

  // Every output decodes straight from a register. No path runs from
  // rk_ready to round_key or round.
  assign bus.busy      = (state == ST_RUN);
  assign bus.rk_valid  = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.round_key = key_reg[KEY_W-1 -: RK_W];
  assign bus.round     = round_q;

endmodule

// File: tb/tb_ksa_controller.sv
// tb_ksa_controller: directed self-checking bench for ksa_controller.
// Each captured key schedule is fed through the bench's own PRESENT-80
// encryption and compared with the published ciphertexts.
// Build option: KSA_CTRL_ABORT_EN enables the abort scenario.
module tb_ksa_controller;

  localparam logic [63:0] SBOX_TAB  = 64'h21748FE3DA09B65C; // nibble i = S(i)
  localparam logic [15:0] READY_PAT = 16'b1001_0110_1100_1011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  logic [63:0] got_key   [32];
  logic [5:0]  got_round [32];
  logic [63:0] model_key [32];

  ksa_controller_if #(.KEY_W(80), .RK_W(64)) bus ();

  ksa_controller #(
    .NUM_ROUNDS (32),
    .KEY_W      (80),
    .RK_W       (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] tab;
    int          idx;
    tab = SBOX_TAB;
    idx = int'(x);
    return tab[4*idx +: 4];
  endfunction

  function automatic logic [79:0] model_step(input logic [79:0] k, input int r);
    logic [79:0] t;
    logic [4:0]  rc;
    rc       = 5'(r);
    t        = (k << 61) | (k >> 19);
    t[79:76] = sb4(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  task automatic build_model(input logic [79:0] key);
    logic [79:0] mk;
    mk = key;
    for (int i = 0; i < 32; i++) begin
      model_key[i] = mk[79:16];
      mk = model_step(mk, i + 1);
    end
  endtask

  // Full PRESENT encryption using the captured round keys.
  function automatic logic [63:0] present_enc(input logic [63:0] pt);
    logic [63:0] st, sb, pl;
    st = pt;
    for (int r = 0; r < 31; r++) begin
      st = st ^ got_key[r];
      for (int j = 0; j < 16; j++) sb[4*j +: 4] = sb4(st[4*j +: 4]);
      pl[63] = sb[63];
      for (int j = 0; j < 63; j++) pl[(j*16) % 63] = sb[j];
      st = pl;
    end
    return st ^ got_key[31];
  endfunction

  // One full schedule. rand_ready applies backpressure. hold_start raises
  // start (with a new key of 0) from round 10 onward, and the schedule that
  // follows must begin right after DONE.
  task automatic do_run(input logic [79:0] key, input bit rand_ready,
                        input bit hold_start, input logic [63:0] kat_ct);
    int   n;
    int   cyc;
    logic ready;
    logic [15:0] pat;
    pat = READY_PAT;
    n   = 0;
    cyc = 0;
    build_model(key);
    bus.key_in = key;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    while (n < 32 && cyc < 400) begin
      ready = rand_ready ? pat[cyc % 16] : 1'b1;
      if (hold_start && bus.round == 6'd10) begin
        bus.start  = 1'b1;
        bus.key_in = 80'h0;
      end
      bus.rk_ready = ready;
      check("rk_valid_run", 80'(bus.rk_valid), 80'(1));
      if (ready) begin
        got_key[n]   = bus.round_key;
        got_round[n] = bus.round;
        n++;
        tick;
      end else begin
        tick;
        check("stall_key", 80'(bus.round_key), 80'(model_key[n]));
        check("stall_round", 80'(bus.round), 80'(n + 1));
      end
      cyc++;
    end
    check("transfers", 80'(n), 80'(32));
    if (!rand_ready) check("cycles", 80'(cyc), 80'(32));
    check("done_pulse", 80'(bus.done), 80'(1));
    check("done_valid", 80'(bus.rk_valid), 80'(0));
    check("done_busy", 80'(bus.busy), 80'(0));
    tick;
    check("done_len", 80'(bus.done), 80'(0));
    check("idle_busy", 80'(bus.busy), 80'(0));
    check("idle_valid", 80'(bus.rk_valid), 80'(0));
    for (int i = 0; i < 32; i++) begin
      check($sformatf("round_%0d", i + 1), 80'(got_round[i]), 80'(i + 1));
      check($sformatf("key_%0d", i + 1), 80'(got_key[i]), 80'(model_key[i]));
    end
    check("kat", 80'(present_enc(64'h0)), 80'(kat_ct));
    if (hold_start) begin
      tick;
      check("restart_valid", 80'(bus.rk_valid), 80'(1));
      check("restart_round", 80'(bus.round), 80'(1));
      check("restart_key", 80'(bus.round_key), 80'(0));
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
`ifdef KSA_CTRL_ABORT_EN
    bus.abort    = 1'b0;
`endif
    #3;
    check("rst_valid", 80'(bus.rk_valid), 80'(0));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_done", 80'(bus.done), 80'(0));
    check("rst_round", 80'(bus.round), 80'(0));
    check("rst_key", 80'(bus.round_key), 80'(0));
    #9 reset = 1'b1;
    tick;

    // All-zero key with no backpressure.
    do_run(80'h0, 1'b0, 1'b0, 64'h5579C1387B228445);
    check("k1_zero", 80'(got_key[0]), 80'(0));
    check("k2_zero", 80'(got_key[1]), 80'(64'hC000000000000000));

    // All-ones key, start held high from round 10 on.
    do_run({80{1'b1}}, 1'b0, 1'b1, 64'hE72C46C0F5945049);

    // Assert reset asynchronously during round 10 of the new schedule.
    bus.rk_ready = 1'b1;
    k = 0;
    while (bus.round != 6'd10 && k < 64) begin
      tick;
      k++;
    end
    check("reach_r10", 80'(bus.round), 80'(10));
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 80'(bus.rk_valid), 80'(0));
    check("arst_busy", 80'(bus.busy), 80'(0));
    check("arst_done", 80'(bus.done), 80'(0));
    check("arst_round", 80'(bus.round), 80'(0));
    check("arst_key", 80'(bus.round_key), 80'(0));
    tick;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_valid", 80'(bus.rk_valid), 80'(0));
      check("post_rst_busy", 80'(bus.busy), 80'(0));
    end

    // Same key as the first run, with ready toggling pseudo-randomly.
    do_run(80'h0, 1'b1, 1'b0, 64'h5579C1387B228445);

`ifdef KSA_CTRL_ABORT_EN
    bus.rk_ready = 1'b1;
    bus.key_in   = 80'h0;
    bus.start    = 1'b1;
    tick;
    bus.start    = 1'b0;
    k = 0;
    while (bus.round != 6'd5 && k < 64) begin
      tick;
      k++;
    end
    check("abort_r5", 80'(bus.round), 80'(5));
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("abort_valid", 80'(bus.rk_valid), 80'(0));
    check("abort_busy", 80'(bus.busy), 80'(0));
    check("abort_done", 80'(bus.done), 80'(0));
    tick;
    check("abort_no_done", 80'(bus.done), 80'(0));
    check("abort_idle", 80'(bus.rk_valid), 80'(0));
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("abort_restart_round", 80'(bus.round), 80'(1));
    check("abort_restart_valid", 80'(bus.rk_valid), 80'(1));
    check("abort_restart_key", 80'(bus.round_key), 80'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
